// File: rtl/midi_rx_decoder.sv
// MIDI 8N1 receiver with a running-status channel-voice parser.
// Drives a monophonic last-note-priority note/gate with velocity.
module midi_rx_decoder #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 31250,
  parameter int CHANNEL  = 0,
  parameter int OMNI     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [6:0] note_velocity,
  output logic       frame_error
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [3:0]    CH   = 4'(CHANNEL);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic          rx_s1_q, rx_s2_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;

  // rs_q[7] doubles as "running status valid" since statuses have bit 7 set
  logic [7:0]    rs_q, rs_d;
  logic          idx_q, idx_d;
  logic [6:0]    note_q, note_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [6:0]    vel_q, vel_d;

  logic cnt_zero;
  logic is_rt, is_sys, is_stat, is_dat;
  logic chan_ok;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s2_q) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s2_q) begin
          state_d = DATA;
          cnt_d   = FULL;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          if (rx_s2_q) begin
            strobe_d = 1'b1;
            byte_d   = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_rt   = byte_q[7:3] == 5'b11111;
  assign is_sys  = byte_q[7:3] == 5'b11110;
  assign is_stat = byte_q[7] && byte_q[7:4] != 4'hF;
  assign is_dat  = !byte_q[7] && rs_q[7];
  assign chan_ok = (OMNI != 0) || (rs_q[3:0] == CH);

  always_comb begin
    rs_d    = rs_q;
    idx_d   = idx_q;
    note_d  = note_q;
    data_d  = data_q;
    valid_d = valid_q;
    vel_d   = vel_q;
    if (strobe_q) begin
      unique case (1'b1)
        is_rt: ;
        is_sys: begin
          rs_d  = '0;
          idx_d = 1'b0;
        end
        is_stat: begin
          rs_d  = byte_q;
          idx_d = 1'b0;
        end
        is_dat: begin
          case (rs_q[6:4])
            3'h0, 3'h1: begin
              if (!idx_q) begin
                note_d = byte_q[6:0];
                idx_d  = 1'b1;
              end else begin
                idx_d = 1'b0;
                if (chan_ok) begin
                  // 0x9_ with nonzero velocity is the only note-on form
                  if (rs_q[4] && byte_q[6:0] != 7'd0) begin
                    data_d  = {1'b0, note_q};
                    vel_d   = byte_q[6:0];
                    valid_d = 1'b1;
                  end else if (valid_q && data_q[6:0] == note_q) begin
                    valid_d = 1'b0;
                  end
                end
              end
            end
            3'h4, 3'h5: ;
            default: idx_d = !idx_q;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      rs_q     <= '0;
      idx_q    <= 1'b0;
      note_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      vel_q    <= '0;
    end else begin
      rx_s1_q  <= midi_rx;
      rx_s2_q  <= rx_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
      rs_q     <= rs_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      vel_q    <= vel_d;
    end
  end

  assign midi_data     = data_q;
  assign midi_valid    = valid_q;
  assign note_velocity = vel_q;
  assign frame_error   = ferr_q;

endmodule

// File: tb/tb_midi_rx_decoder.sv
// Bench for midi_rx_decoder: two instances (channel 0 and omni)
// compared every cycle against a message-level model.
module tb_midi_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       midi_rx = 1'b1;
  logic [7:0] md0, md1;
  logic       mv0, mv1, fe0, fe1;
  logic [6:0] ve0, ve1;

  always #5 clk = ~clk;

  midi_rx_decoder #(
    .CLK_FREQ(1_000_000), .BAUD(31250), .CHANNEL(0), .OMNI(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .midi_rx(midi_rx),
    .midi_data(md0), .midi_valid(mv0),
    .note_velocity(ve0), .frame_error(fe0)
  );

  midi_rx_decoder #(
    .CLK_FREQ(1_000_000), .BAUD(31250), .CHANNEL(0), .OMNI(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .midi_rx(midi_rx),
    .midi_data(md1), .midi_valid(mv1),
    .note_velocity(ve1), .frame_error(fe1)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int ferr_cnt = 0;

  // model: running status (-1 = none), bytes collected for the message
  int m_rs[2];
  int m_got[2];
  int m_first[2];
  int m_data[2];
  int m_vel[2];
  bit m_valid[2];
  bit exp_ferr = 1'b0;

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_rs[m] = -1; m_got[m] = 0; m_first[m] = 0;
      m_data[m] = 0; m_vel[m] = 0; m_valid[m] = 1'b0;
    end
    exp_ferr = 1'b0;
  endfunction

  function automatic void model_byte(int b);
    for (int m = 0; m < 2; m++) begin
      int kind, len;
      if (b >= 'hF8) continue;
      if (b >= 'hF0) begin m_rs[m] = -1; m_got[m] = 0; continue; end
      if (b >= 'h80) begin m_rs[m] = b; m_got[m] = 0; continue; end
      if (m_rs[m] < 0) continue;
      kind = m_rs[m] / 16;
      len = (kind == 'hC || kind == 'hD) ? 1 : 2;
      if (m_got[m] == 0) m_first[m] = b;
      m_got[m]++;
      if (m_got[m] < len) continue;
      m_got[m] = 0;
      if (kind != 8 && kind != 9) continue;
      if (m == 0 && (m_rs[m] % 16) != 0) continue;
      if (kind == 9 && b > 0) begin
        m_data[m] = m_first[m]; m_vel[m] = b; m_valid[m] = 1'b1;
      end else if (m_valid[m] && m_data[m] == m_first[m]) begin
        m_valid[m] = 1'b0;
      end
    end
  endfunction

  task automatic cmp(input int m, input logic [7:0] d, input logic v,
                     input logic [6:0] ve, input logic fe);
    bit bad;
    bad = (d !== 8'(m_data[m])) || (v !== m_valid[m]) ||
          (ve !== 7'(m_vel[m])) || (fe !== exp_ferr);
    vectors++;
    if (bad) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL cyc dut%0d t=%0t got d=%h v=%b vel=%h fe=%b exp d=%h v=%b vel=%h fe=%b",
                 m, $time, d, v, ve, fe, 8'(m_data[m]), m_valid[m],
                 7'(m_vel[m]), exp_ferr);
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        cmp(0, md0, mv0, ve0, fe0);
        cmp(1, md1, mv1, ve1, fe1);
        if (fe0 === 1'b1) ferr_cnt++;
      end
    end
  end

  // one 8N1 frame of 320 cycles; rst_at >= 0 pulses reset at that cycle
  task automatic send(input int b, input bit stop_ok = 1'b1,
                      input int rst_at = -1);
    logic [7:0] bb;
    bb = 8'(b);
    for (int i = 0; i < 320; i++) begin
      int k;
      @(negedge clk);
      k = i / 32;
      midi_rx = (k == 0) ? 1'b0 : (k <= 8) ? bb[k-1] : stop_ok;
      rst_n = (i != rst_at);
      if (i == rst_at) model_reset();
      if (rst_at < 0) begin
        if (i == 306 && !stop_ok) exp_ferr = 1'b1;
        if (i == 307) begin
          exp_ferr = 1'b0;
          if (stop_ok) model_byte(b);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      midi_rx = 1'b1;
    end
  endtask

  task automatic msg(input int a, input int b, input int c);
    send(a); send(b); send(c);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    lit("reset_data", md0, 0);
    lit("reset_valid", mv0, 0);
    idle(40);

    msg('h90, 'h3C, 'h64);
    lit("on_data", md0, 'h3C);
    lit("on_valid", mv0, 1);
    lit("on_vel", ve0, 'h64);

    send('h40); send('h50);
    lit("rs_data", md0, 'h40);
    lit("rs_vel", ve0, 'h50);

    msg('h80, 'h3C, 'h00);
    lit("off_miss_valid", mv0, 1);

    msg('h90, 'h40, 'h00);
    lit("off_hit_valid", mv0, 0);
    lit("off_hit_data", md0, 'h40);
    idle(5);

    send('h90); send('h45); send('hF8); send('h7F);
    lit("rt_data", md0, 'h45);
    lit("rt_vel", ve0, 'h7F);
    lit("rt_valid", mv0, 1);

    msg('hF0, 'h45, 'h10);
    lit("sysex_data", md0, 'h45);

    msg('h91, 'h30, 'h40);
    lit("chan_filt_data", md0, 'h45);
    lit("omni_data", md1, 'h30);
    lit("omni_valid", mv1, 1);

    send('h90);
    send('h12, 1'b0);
    idle(64);
    lit("ferr_pulses", ferr_cnt, 1);
    send('h3C); send('h64);
    lit("post_ferr_data", md0, 'h3C);
    lit("post_ferr_vel", ve0, 'h64);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      midi_rx = 1'b0;
    end
    idle(60);
    lit("glitch_ferr", ferr_cnt, 1);

    send('h90); send('h3C);
    send('h64, 1'b1, 230);
    idle(400);
    lit("rst_data", md0, 0);
    lit("rst_valid", mv0, 0);
    lit("rst_vel", ve0, 0);
    msg('h90, 'h3C, 'h64);
    lit("rst_again_data", md0, 'h3C);
    lit("rst_again_valid", mv0, 1);

    for (int n = 0; n < 80; n++) begin
      int r, b;
      r = $urandom_range(0, 11);
      case (r)
        0: b = 'h90 | $urandom_range(0, 1);
        1: b = 'h80 | $urandom_range(0, 1);
        2: b = 'hF8 + $urandom_range(0, 7);
        3: b = 'hF0 + $urandom_range(0, 7);
        4: b = ($urandom_range(0, 1) != 0) ? 'hA0 : 'hC0 + $urandom_range(0, 0);
        5: b = 'hE0 | $urandom_range(0, 1);
        default: b = ($urandom_range(0, 3) == 0) ? 0 : 60 + $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 11) == 0) begin
        send(b, 1'b0);
        idle(40 + $urandom_range(0, 20));
      end else begin
        send(b);
        idle($urandom_range(0, 20));
      end
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/midi_rx_decoder.md
# midi_rx_decoder

Serial MIDI front end that produces the note stream consumed by `midi_player`. It samples a 31250-baud MIDI line with an 8N1 UART receiver and parses channel-voice messages with running status. It drives a monophonic, last-note-priority note/gate interface (`midi_data`, `midi_valid`) plus velocity. It sits between the board's MIDI input pin and the synth voice.

## Interface
- `CLK_FREQ`, 12_000_000: system clock frequency in Hz.
- `BAUD`, 31250: serial bit rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division; must be ≥ 8).
- `CHANNEL`, 0: MIDI channel 0–15 accepted when `OMNI` = 0.
- `OMNI`, 0: 1 = accept note messages on every channel.

- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `midi_rx`  in  1  asynchronous serial MIDI line, idle high.
- `midi_data`  out  8  current note number, bit 7 always 0.
- `midi_valid`  out  1  gate: high while the current note is held.
- `note_velocity`  out  7  velocity of the last accepted note-on.
- `frame_error`  out  1  one-cycle pulse on a bad stop bit.

## Operation
- Input sync: two-flop synchronizer on `midi_rx`; synchronizer resets to 1.
- UART FSM with states IDLE, START, DATA, STOP:
  - IDLE: a synced 0 enters START and loads the bit counter with `CLKS_PER_BIT/2 - 1`.
  - START: at the mid-bit sample, line 0 → DATA; line 1 → IDLE (false start, no error).
  - DATA: 8 samples spaced `CLKS_PER_BIT` apart, LSB first.
  - STOP: one sample. Line 1 → 1-cycle `byte_strobe` with the assembled byte, then IDLE. Line 0 → `frame_error` pulse, byte discarded, then IDLE. Running status and parser state are unchanged on a frame error.
- Parser, driven by `byte_strobe`:
  - 0xF8–0xFF (real-time): ignored completely. Running status and data-byte index are untouched.
  - 0xF0–0xF7: clears running status. All following data bytes are discarded until the next channel status byte.
  - 0x80–0xEF: latches running status and resets the data-byte index to 0.
  - Data byte (bit 7 = 0) with no running status: discarded.
  - Data byte with running status 0xC_/0xD_: one-byte messages, ignored.
  - Data byte with running status 0xA_/0xB_/0xE_: two-byte messages, ignored. The index still toggles.
  - Data byte with running status 0x8_/0x9_: index 0 stores the note; index 1 completes the message and the index returns to 0. Running status persists after completion.
  - Channel filter: the message is acted on only if `OMNI` = 1 or the status low nibble equals `CHANNEL`.
- Note actions at message completion:
  - Note-on with velocity > 0: `midi_data` = note, `note_velocity` = velocity, `midi_valid` = 1. This replaces any current note (last-note priority).
  - Note-off (0x8_), or note-on with velocity 0: if the note equals `midi_data` and `midi_valid` = 1, then `midi_valid` = 0. Otherwise no change. `midi_data` and `note_velocity` hold their values.

## Timing
- Reset: `midi_data` = 0, `midi_valid` = 0, `note_velocity` = 0, `frame_error` = 0. UART goes to IDLE, running status is cleared, data index = 0. Reset mid-frame aborts the frame; the next falling edge starts a fresh frame.
- Input latency: 2 cycles through the synchronizer.
- Sample points, relative to the synced falling edge:
  - start bit: `CLKS_PER_BIT/2`
  - data bit k: `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT`
  - stop bit: `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT`
- `byte_strobe`/`frame_error`: asserted in the cycle after the stop sample edge, for exactly 1 cycle.
- Outputs update on the clock edge that consumes `byte_strobe`, which is 2 cycles after the stop sample edge.
- IDLE detects a new start bit in the cycle right after STOP, so back-to-back frames with zero idle time are supported.
- `midi_data`, `midi_valid` and `note_velocity` are registered and glitch-free. They change only on message completion or reset.

## Test plan
Bench settings: `CLK_FREQ` = 1_000_000, `BAUD` = 31250 (`CLKS_PER_BIT` = 32), `CHANNEL` = 0, `OMNI` = 0.

- Send 0x90 0x3C 0x64 → `midi_data` = 0x3C, `midi_valid` = 1, `note_velocity` = 0x64. Outputs update 2 cycles after the last stop-bit sample.
- Running status, then mismatched and matched offs:
  - Follow with 0x40 0x50 → `midi_data` = 0x40, `note_velocity` = 0x50.
  - Send 0x80 0x3C 0x00 → no change.
  - Send 0x90 0x40 0x00 → `midi_valid` = 0, `midi_data` stays 0x40.
- Insert 0xF8 between note and velocity, e.g. 0x90 0x45 0xF8 0x7F → note 0x45 accepted with velocity 0x7F. Then 0xF0 0x45 0x10 → no change.
- Channel filter: 0x91 0x30 0x40 → outputs unchanged. Repeat with `OMNI` = 1 → `midi_data` = 0x30, `midi_valid` = 1.
- Framing errors:
  - Frame with stop bit held low → one `frame_error` pulse, byte discarded, parser state intact. The following valid 0x3C 0x64 (running status 0x90) still plays.
  - 0 glitch shorter than `CLKS_PER_BIT/2` → no byte, no error.
- Assert `rst_n` = 0 for 1 cycle during DATA of the byte 0x64 after 0x90 0x3C → all outputs 0. The next full 0x90 0x3C 0x64 decodes normally.
